// File: rtl/uart_tx_serializer_if.sv
// Parallel-word handshake between a producer and the UART transmit serializer.
// The producer drives the word and its valid flag; the serializer answers with tx_ready.
interface uart_tx_serializer_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bits.
// A one-word holding register lets the next frame start with no idle gap after the last stop bit.
module uart_tx_serializer #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      tick,
   uart_tx_serializer_if.slave       bus,
   output logic                      tx,
   output logic                      busy
);
   localparam int CNT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_serializer: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state, state_n;
   logic                 tx_n;
   logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
   logic                 stop_cnt, stop_cnt_n;
   logic                 hold_empty;
   logic [DATA_BITS-1:0] hold;
   logic [DATA_BITS-1:0] shifter;
   logic                 parity_q;
   logic                 accept;
   logic                 load;
   logic                 shift;

   function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
      return (PARITY == 1) ? ~^word : ^word;
   endfunction

   // hold_empty is the ready flop itself, so tx_ready has no path from tx_valid
   assign accept       = bus.tx_valid & hold_empty;
   assign bus.tx_ready = hold_empty;
   assign busy         = (state != IDLE) | ~hold_empty;

   always_comb begin
      state_n    = state;
      tx_n       = tx;
      bit_cnt_n  = bit_cnt;
      stop_cnt_n = stop_cnt;
      load       = 1'b0;
      shift      = 1'b0;
      if (tick) begin
         case (state)
            IDLE: begin
               if (!hold_empty) begin
                  tx_n    = 1'b0;
                  load    = 1'b1;
                  state_n = START;
               end
            end
            START: begin
               tx_n      = shifter[0];
               bit_cnt_n = '0;
               state_n   = DATA;
            end
            DATA: begin
               if (bit_cnt < LAST_BIT) begin
                  shift     = 1'b1;
                  tx_n      = shifter[1];
                  bit_cnt_n = bit_cnt + 1'b1;
               end else if (PARITY != 0) begin
                  tx_n    = parity_q;
                  state_n = PAR;
               end else begin
                  tx_n       = 1'b1;
                  stop_cnt_n = 1'b0;
                  state_n    = STOP;
               end
            end
            PAR: begin
               tx_n       = 1'b1;
               stop_cnt_n = 1'b0;
               state_n    = STOP;
            end
            STOP: begin
               if (stop_cnt < LAST_STOP) begin
                  stop_cnt_n = 1'b1;
               end else if (!hold_empty) begin
                  // next word already waiting: its start bit follows this stop bit directly
                  tx_n    = 1'b0;
                  load    = 1'b1;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         tx         <= 1'b1;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         hold_empty <= 1'b1;
      end else begin
         state    <= state_n;
         tx       <= tx_n;
         bit_cnt  <= bit_cnt_n;
         stop_cnt <= stop_cnt_n;
         if (accept)
            hold_empty <= 1'b0;
         else if (load)
            hold_empty <= 1'b1;
      end
   end

   // Data path carries no reset; its contents only matter once hold_empty/state say so
   always_ff @(posedge clk) begin
      if (accept)
         hold <= bus.tx_data;
      if (load) begin
         shifter  <= hold;
         parity_q <= parity_of(hold);
      end else if (shift) begin
         shifter <= shifter >> 1;
      end
   end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four instances cover no parity, even, odd and two stop bits.
module tb_uart_tx_serializer;
   logic       clk;
   logic       reset;
   logic       tick;
   logic [1:0] tick_cnt;
   logic [7:0] dat [4];
   logic [3:0] vld;
   wire  [3:0] rdy;
   wire  [3:0] txo;
   wire  [3:0] bsy;
   int         checks;
   int         errors;

   uart_tx_serializer_if #(.DATA_BITS(8)) b0 ();
   uart_tx_serializer_if #(.DATA_BITS(8)) b1 ();
   uart_tx_serializer_if #(.DATA_BITS(8)) b2 ();
   uart_tx_serializer_if #(.DATA_BITS(8)) b3 ();

   assign b0.tx_data = dat[0];  assign b0.tx_valid = vld[0];  assign rdy[0] = b0.tx_ready;
   assign b1.tx_data = dat[1];  assign b1.tx_valid = vld[1];  assign rdy[1] = b1.tx_ready;
   assign b2.tx_data = dat[2];  assign b2.tx_valid = vld[2];  assign rdy[2] = b2.tx_ready;
   assign b3.tx_data = dat[3];  assign b3.tx_valid = vld[3];  assign rdy[3] = b3.tx_ready;

   uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_none (
      .clk(clk), .reset(reset), .tick(tick), .bus(b0), .tx(txo[0]), .busy(bsy[0]));
   uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
      .clk(clk), .reset(reset), .tick(tick), .bus(b1), .tx(txo[1]), .busy(bsy[1]));
   uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
      .clk(clk), .reset(reset), .tick(tick), .bus(b2), .tx(txo[2]), .busy(bsy[2]));
   uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_stop2 (
      .clk(clk), .reset(reset), .tick(tick), .bus(b3), .tx(txo[3]), .busy(bsy[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Baud tick: one clk high out of every four, changed on the falling edge
   initial begin
      tick     = 1'b0;
      tick_cnt = 2'd0;
   end
   always @(negedge clk) begin
      tick_cnt <= tick_cnt + 2'd1;
      tick     <= (tick_cnt == 2'd3);
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (tick !== 1'b1 && n < 8);
      if (tick !== 1'b1) begin
         errors++;
         $error("FAIL tick_timeout observed none expected tick");
      end
   endtask

   task automatic send(input int i, input logic [7:0] d);
      int n = 0;
      @(negedge clk);
      #1;
      while (rdy[i] !== 1'b1 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      dat[i] = d;
      vld[i] = 1'b1;
      @(posedge clk);
      #1;
      vld[i] = 1'b0;
      chk($sformatf("send%0d_ready_low", i), rdy[i], 1'b0);
      chk($sformatf("send%0d_busy", i), bsy[i], 1'b1);
   endtask

   // Holds tx_valid on instance 0 until the word is taken, then drops it
   task automatic queue_bg0(input logic [7:0] d);
      dat[0] = d;
      vld[0] = 1'b1;
      fork
         begin
            int n = 0;
            do begin
               @(negedge clk);
               #1;
               n++;
            end while (rdy[0] !== 1'b1 && n < 200);
            @(posedge clk);
            #1;
            vld[0] = 1'b0;
         end
      join_none
   endtask

   task automatic check_bits(input int i, input logic [11:0] seq, input int k0, input int k1,
                             input string tag);
      for (int k = k0; k <= k1; k++) begin
         wait_tick();
         #1;
         chk($sformatf("%s_b%0d", tag, k), txo[i], seq[k]);
         repeat (4) @(negedge clk);
         chk($sformatf("%s_b%0d_hold", tag, k), txo[i], seq[k]);
      end
   endtask

   task automatic check_idle(input int i, input string tag);
      chk({tag, "_busy_in_stop"}, bsy[i], 1'b1);
      wait_tick();
      #1;
      chk({tag, "_idle_tx"}, txo[i], 1'b1);
      chk({tag, "_idle_busy"}, bsy[i], 1'b0);
      chk({tag, "_idle_ready"}, rdy[i], 1'b1);
   endtask

   initial begin
      int txbad;
      int bsybad;
      int n;
      checks = 0;
      errors = 0;
      vld    = 4'b0000;
      for (int i = 0; i < 4; i++) dat[i] = 8'h00;
      reset = 1'b1;
      #2;
      chk("reset_tx", txo, 4'b1111);
      chk("reset_ready", rdy, 4'b1111);
      chk("reset_busy", bsy, 4'b0000);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // 0x55, no parity, one stop bit
      send(0, 8'h55);
      check_bits(0, {2'b00, 1'b1, 8'h55, 1'b0}, 0, 9, "t1");
      check_idle(0, "t1");

      // 0x07 with even parity (bit 1) and odd parity (bit 0), 11-bit frames
      send(1, 8'h07);
      check_bits(1, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 0, 10, "t2even");
      check_idle(1, "t2even");
      send(2, 8'h07);
      check_bits(2, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 0, 10, "t2odd");
      check_idle(2, "t2odd");

      // back-to-back 0xA5 then 0x3C with tx_valid held
      @(negedge clk);
      #1;
      dat[0] = 8'hA5;
      vld[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("t3_ready_full1", rdy[0], 1'b0);
      queue_bg0(8'h3C);
      wait_tick();
      #1;
      chk("t3_start1", txo[0], 1'b0);
      chk("t3_ready_drain1", rdy[0], 1'b1);
      repeat (4) @(negedge clk);
      chk("t3_start1_hold", txo[0], 1'b0);
      chk("t3_ready_full2", rdy[0], 1'b0);
      check_bits(0, {2'b00, 1'b1, 8'hA5, 1'b0}, 1, 9, "t3f1");
      wait_tick();
      #1;
      chk("t3_start2_no_gap", txo[0], 1'b0);
      chk("t3_ready_drain2", rdy[0], 1'b1);
      chk("t3_busy_between", bsy[0], 1'b1);
      repeat (4) @(negedge clk);
      chk("t3_start2_hold", txo[0], 1'b0);
      check_bits(0, {2'b00, 1'b1, 8'h3C, 1'b0}, 1, 9, "t3f2");
      check_idle(0, "t3");

      // two stop bits after 0xFF
      send(3, 8'hFF);
      check_bits(3, {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 0, 10, "t4");
      check_idle(3, "t4");

      // accept on the same edge as a tick: start bit waits for the next tick
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (tick !== 1'b1 && n < 8);
      dat[0] = 8'h81;
      vld[0] = 1'b1;
      @(posedge clk);
      #1;
      vld[0] = 1'b0;
      chk("t5_tx_on_accept_tick", txo[0], 1'b1);
      chk("t5_ready_low", rdy[0], 1'b0);
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("t5_still_idle_c%0d", c), txo[0], 1'b1);
      end
      @(posedge clk);
      #1;
      chk("t5_start_next_tick", txo[0], 1'b0);
      check_bits(0, {2'b00, 1'b1, 8'h81, 1'b0}, 1, 9, "t5");
      check_idle(0, "t5");

      // reset during data bit 3 of 0x0F with a second word pending
      send(0, 8'h0F);
      queue_bg0(8'h00);
      check_bits(0, {2'b00, 1'b1, 8'h0F, 1'b0}, 0, 4, "t6");
      chk("t6_pending_ready", rdy[0], 1'b0);
      chk("t6_pending_busy", bsy[0], 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_async_tx", txo[0], 1'b1);
      chk("t6_async_ready", rdy[0], 1'b1);
      chk("t6_async_busy", bsy[0], 1'b0);
      @(negedge clk);
      reset = 1'b0;
      txbad  = 0;
      bsybad = 0;
      repeat (60) begin
         @(negedge clk);
         if (txo[0] !== 1'b1) txbad++;
         if (bsy[0] !== 1'b0) bsybad++;
      end
      chk("t6_no_resume_tx", 16'(txbad), 16'd0);
      chk("t6_no_resume_busy", 16'(bsybad), 16'd0);
      chk("t6_ready_after", rdy[0], 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
